dbus_wb_bridge: RTL and testbench



---
 rtl/rv32i_mem_pkg.sv | 59 +++++
 rtl/dbus_lane_unit.sv | 28 ++
 rtl/dbus_wb_bridge.sv | 132 +++++++++++++
 tb/tb_dbus_wb_bridge.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_mem_pkg.sv
// rv32i_mem_pkg: shared types and lane helpers for the data-side bus bridge.
//   mem_op_e     : load/store width encodings (funct3)
//   dbus_state_e : bridge FSM states
//   sel_gen / wdata_steer / rdata_extract / is_misaligned : byte-lane helpers
package rv32i_mem_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    DONE
  } dbus_state_e;

  // Undefined op encodings fall into the default arm and behave as word accesses.
  function automatic logic [3:0] sel_gen(input logic [2:0] op, input logic [1:0] off);
    case (op)
      MEM_B, MEM_BU: sel_gen = 4'b0001 << off;
      MEM_H, MEM_HU: sel_gen = 4'b0011 << off;
      default:       sel_gen = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_steer(input logic [2:0] op, input logic [31:0] wdata);
    case (op)
      MEM_B, MEM_BU: wdata_steer = {4{wdata[7:0]}};
      MEM_H, MEM_HU: wdata_steer = {2{wdata[15:0]}};
      default:       wdata_steer = wdata;
    endcase
  endfunction

  function automatic logic [31:0] rdata_extract(input logic [2:0] op, input logic [1:0] off,
                                                input logic [31:0] data);
    logic [31:0] sh;
    sh = data >> {off, 3'b000};
    case (op)
      MEM_B:   rdata_extract = {{24{sh[7]}}, sh[7:0]};
      MEM_BU:  rdata_extract = {24'h0, sh[7:0]};
      MEM_H:   rdata_extract = {{16{sh[15]}}, sh[15:0]};
      MEM_HU:  rdata_extract = {16'h0, sh[15:0]};
      default: rdata_extract = data;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
    case (op)
      MEM_B, MEM_BU: is_misaligned = 1'b0;
      MEM_H, MEM_HU: is_misaligned = off[0];
      default:       is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dbus_lane_unit.sv
// dbus_lane_unit: combinational byte-lane logic for the data bus bridge.
//   req_op/req_off/req_wdata : incoming request (select, store steering, alignment)
//   rsp_op/rsp_off/rsp_data  : latched load info plus raw bus read data
//   sel/wdata/misaligned     : request-side results
//   rdata                    : right-justified, extended load data
module dbus_lane_unit
  import rv32i_mem_pkg::*;
(
  input  logic [2:0]  req_op,
  input  logic [1:0]  req_off,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  rsp_op,
  input  logic [1:0]  rsp_off,
  input  logic [31:0] rsp_data,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic        misaligned,
  output logic [31:0] rdata
);

  always_comb begin
    sel        = sel_gen(req_op, req_off);
    wdata      = wdata_steer(req_op, req_wdata);
    misaligned = is_misaligned(req_op, req_off);
    rdata      = rdata_extract(rsp_op, rsp_off, rsp_data);
  end

endmodule

// File: rtl/dbus_wb_bridge.sv
// dbus_wb_bridge: MEM-stage load/store to Wishbone B4 classic master.
//   clk_i, reset_i (async, active-high)
//   mem_*        : core side request (addr, wdata, read/write, op) and response
//                  (rdata, one-cycle ack, err qualified by ack)
//   stall_pipl_o : holds the pipeline while a request is being served
//   wb_*         : Wishbone master signals; cyc/stb high only in BUS
module dbus_wb_bridge
  import rv32i_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic        mem_write_i,
  input  logic        mem_read_i,
  input  logic [2:0]  mem_op_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        mem_err_o,
  output logic        stall_pipl_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  dbus_state_e      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       rsp_op;
  logic [1:0]       rsp_off;

  logic             req;
  logic [3:0]       lane_sel;
  logic [31:0]      lane_wdata;
  logic             lane_misaligned;
  logic [31:0]      lane_rdata;

  assign req          = mem_read_i | mem_write_i;
  assign stall_pipl_o = ((state == IDLE) && req) || (state == BUS);

  dbus_lane_unit u_lane (
    .req_op     (mem_op_i),
    .req_off    (mem_addr_i[1:0]),
    .req_wdata  (mem_wdata_i),
    .rsp_op     (rsp_op),
    .rsp_off    (rsp_off),
    .rsp_data   (wb_dat_i),
    .sel        (lane_sel),
    .wdata      (lane_wdata),
    .misaligned (lane_misaligned),
    .rdata      (lane_rdata)
  );

  // mem_ack_o is set on entry to DONE and cleared on the way out, so it is
  // high exactly for the DONE cycle; mem_rdata_o/mem_err_o persist until the next DONE.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      cnt         <= '0;
      rsp_op      <= '0;
      rsp_off     <= '0;
      mem_rdata_o <= '0;
      mem_ack_o   <= 1'b0;
      mem_err_o   <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      wb_we_o     <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
    end else begin
      mem_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (lane_misaligned) begin
              mem_err_o   <= 1'b1;
              mem_rdata_o <= '0;
              mem_ack_o   <= 1'b1;
              state       <= DONE;
            end else begin
              wb_adr_o <= {mem_addr_i[31:2], 2'b00};
              wb_sel_o <= lane_sel;
              wb_dat_o <= lane_wdata;
              wb_we_o  <= mem_write_i;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
              rsp_op   <= mem_op_i;
              rsp_off  <= mem_addr_i[1:0];
              cnt      <= '0;
              state    <= BUS;
            end
          end
        end
        BUS: begin
          cnt <= cnt + CNT_W'(1);
          if (wb_err_i) begin
            mem_err_o   <= 1'b1;
            mem_rdata_o <= '0;
          end else if (wb_ack_i) begin
            mem_err_o   <= 1'b0;
            mem_rdata_o <= lane_rdata;
          end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            mem_err_o   <= 1'b1;
            mem_rdata_o <= '0;
          end
          if (wb_err_i || wb_ack_i || (cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            mem_ack_o <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          // Request is still visible here; it is intentionally not re-examined.
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_wb_bridge.sv
// tb_dbus_wb_bridge: directed checks of dbus_wb_bridge against a simple
// Wishbone slave with programmable wait states and response mode.
module tb_dbus_wb_bridge;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic        mem_write_i, mem_read_i;
  logic [2:0]  mem_op_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o, mem_err_o, stall_pipl_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;

  int n_cmp = 0;
  int n_err = 0;

  // slave control: mode 0 = ack after sl_waits, 1 = never respond, 2 = ack+err together
  int          sl_mode  = 0;
  int          sl_waits = 0;
  logic [31:0] sl_data  = '0;
  int          wcnt     = 0;
  int          bus_starts = 0;

  // per-access observations
  int          r_ack_k, r_stalls, r_cyc_n;
  logic        r_err, r_we;
  logic [31:0] r_rdata, r_adr, r_dat;
  logic [3:0]  r_sel;

  always #5 clk_i = ~clk_i;

  dbus_wb_bridge #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .mem_addr_i   (mem_addr_i),
    .mem_wdata_i  (mem_wdata_i),
    .mem_write_i  (mem_write_i),
    .mem_read_i   (mem_read_i),
    .mem_op_i     (mem_op_i),
    .mem_rdata_o  (mem_rdata_o),
    .mem_ack_o    (mem_ack_o),
    .mem_err_o    (mem_err_o),
    .stall_pipl_o (stall_pipl_o),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_sel_o     (wb_sel_o),
    .wb_we_o      (wb_we_o),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_dat_i     (wb_dat_i),
    .wb_ack_i     (wb_ack_i),
    .wb_err_i     (wb_err_i)
  );

  always @(posedge wb_cyc_o) bus_starts++;

  always @(negedge clk_i) begin
    if (wb_cyc_o && wb_stb_o) begin
      if (sl_mode == 1) begin
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
      end else if (wcnt == sl_waits) begin
        wb_ack_i = 1'b1;
        wb_err_i = (sl_mode == 2);
        wb_dat_i = sl_data;
      end else begin
        wcnt++;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
      end
    end else begin
      wcnt     = 0;
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called #1 after a posedge. Holds the request through DONE, as the core does.
  task automatic access(input logic wr, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wdata);
    bit seen;
    mem_write_i = wr;
    mem_read_i  = ~wr;
    mem_op_i    = op;
    mem_addr_i  = addr;
    mem_wdata_i = wdata;
    #1;
    r_stalls = int'(stall_pipl_o);
    r_cyc_n  = 0;
    r_ack_k  = 0;
    seen     = 1'b0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(posedge clk_i);
      #1;
      if (wb_cyc_o) begin
        if (r_cyc_n == 0) begin
          r_sel = wb_sel_o;
          r_adr = wb_adr_o;
          r_dat = wb_dat_o;
          r_we  = wb_we_o;
        end
        r_cyc_n++;
      end
      if (mem_ack_o) begin
        seen    = 1'b1;
        r_ack_k = k;
        r_err   = mem_err_o;
        r_rdata = mem_rdata_o;
        chk("done_stall", {31'h0, stall_pipl_o}, 0);
        chk("done_cyc", {31'h0, wb_cyc_o}, 0);
      end else begin
        r_stalls += int'(stall_pipl_o);
      end
    end
    if (!seen) chk("ack_seen", 0, 1);
    @(posedge clk_i);
    #1;
    chk("ack_one_cycle", {31'h0, mem_ack_o}, 0);
    chk("no_reissue", {31'h0, wb_cyc_o}, 0);
    mem_write_i = 1'b0;
    mem_read_i  = 1'b0;
  endtask

  initial begin
    int b0;
    reset_i     = 1'b1;
    mem_addr_i  = '0;
    mem_wdata_i = '0;
    mem_write_i = 1'b0;
    mem_read_i  = 1'b0;
    mem_op_i    = 3'b010;
    wb_dat_i    = '0;
    wb_ack_i    = 1'b0;
    wb_err_i    = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_stall", {31'h0, stall_pipl_o}, 0);
    chk("rst_ack", {31'h0, mem_ack_o}, 0);
    chk("rst_err", {31'h0, mem_err_o}, 0);
    chk("rst_cyc", {30'h0, wb_cyc_o, wb_stb_o}, 0);
    chk("rst_sel", {28'h0, wb_sel_o}, 0);
    chk("rst_rdata", mem_rdata_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;

    // SW 0x100, zero wait
    sl_mode = 0; sl_waits = 0; sl_data = 32'h0;
    access(1'b1, 3'b010, 32'h100, 32'hDEADBEEF);
    chk("sw_sel", {28'h0, r_sel}, 32'hF);
    chk("sw_we", {31'h0, r_we}, 1);
    chk("sw_adr", r_adr, 32'h100);
    chk("sw_dat", r_dat, 32'hDEADBEEF);
    chk("sw_stalls", r_stalls, 2);
    chk("sw_ack_k", r_ack_k, 2);
    chk("sw_err", {31'h0, r_err}, 0);

    // LB / LBU at 0x203
    sl_data = 32'h80FF1234;
    access(1'b0, 3'b000, 32'h203, 32'h0);
    chk("lb_sel", {28'h0, r_sel}, 32'h8);
    chk("lb_adr", r_adr, 32'h200);
    chk("lb_we", {31'h0, r_we}, 0);
    chk("lb_rdata", r_rdata, 32'hFFFFFF80);
    access(1'b0, 3'b100, 32'h203, 32'h0);
    chk("lbu_rdata", r_rdata, 32'h00000080);

    // SH / LH at 0x302
    access(1'b1, 3'b001, 32'h302, 32'h0000ABCD);
    chk("sh_sel", {28'h0, r_sel}, 32'hC);
    chk("sh_dat", r_dat, 32'hABCDABCD);
    sl_data = 32'hABCD0000;
    access(1'b0, 3'b001, 32'h302, 32'h0);
    chk("lh_rdata", r_rdata, 32'hFFFFABCD);
    access(1'b0, 3'b101, 32'h302, 32'h0);
    chk("lhu_rdata", r_rdata, 32'h0000ABCD);

    // undefined op 011 behaves as word
    sl_data = 32'h13579BDF;
    access(1'b0, 3'b011, 32'h500, 32'h0);
    chk("undef_sel", {28'h0, r_sel}, 32'hF);
    chk("undef_rdata", r_rdata, 32'h13579BDF);

    // misaligned LW at 0x401
    b0 = bus_starts;
    access(1'b0, 3'b010, 32'h401, 32'h0);
    chk("mis_cyc", r_cyc_n, 0);
    chk("mis_starts", bus_starts - b0, 0);
    chk("mis_ack_k", r_ack_k, 1);
    chk("mis_stalls", r_stalls, 1);
    chk("mis_err", {31'h0, r_err}, 1);

    // aligned load after a misaligned one clears the error
    sl_data = 32'h00C0FFEE;
    access(1'b0, 3'b010, 32'h404, 32'h0);
    chk("clr_err", {31'h0, r_err}, 0);
    chk("clr_rdata", r_rdata, 32'h00C0FFEE);

    // timeout: TIMEOUT_CYCLES=4
    sl_mode = 1;
    access(1'b0, 3'b010, 32'h600, 32'h0);
    chk("to_cyc", r_cyc_n, 4);
    chk("to_ack_k", r_ack_k, 5);
    chk("to_err", {31'h0, r_err}, 1);
    chk("to_rdata", r_rdata, 0);

    // err together with ack: err wins
    sl_mode = 2; sl_waits = 0; sl_data = 32'h12345678;
    access(1'b0, 3'b010, 32'h700, 32'h0);
    chk("ae_err", {31'h0, r_err}, 1);
    chk("ae_rdata", r_rdata, 0);
    chk("ae_ack_k", r_ack_k, 2);

    // back-to-back LW, 3 wait states
    sl_mode = 0; sl_waits = 3;
    b0 = bus_starts;
    sl_data = 32'h11223344;
    access(1'b0, 3'b010, 32'h800, 32'h0);
    chk("b2b1_rdata", r_rdata, 32'h11223344);
    chk("b2b1_ack_k", r_ack_k, 5);
    chk("b2b1_cyc", r_cyc_n, 4);
    sl_data = 32'h55667788;
    access(1'b0, 3'b010, 32'h804, 32'h0);
    chk("b2b2_rdata", r_rdata, 32'h55667788);
    chk("b2b2_adr", r_adr, 32'h804);
    chk("b2b_starts", bus_starts - b0, 2);

    // reset mid-BUS
    sl_mode = 1;
    mem_read_i = 1'b1; mem_op_i = 3'b010; mem_addr_i = 32'h900;
    @(posedge clk_i);
    #1;
    chk("mr_cyc_before", {31'h0, wb_cyc_o}, 1);
    #2;
    mem_read_i = 1'b0;
    reset_i    = 1'b1;
    #1;
    chk("mr_cyc_async", {31'h0, wb_cyc_o}, 0);
    chk("mr_stb_async", {31'h0, wb_stb_o}, 0);
    chk("mr_ack", {31'h0, mem_ack_o}, 0);
    @(negedge clk_i);
    reset_i = 1'b0;
    b0 = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk_i);
      #1;
      if (mem_ack_o || wb_cyc_o || stall_pipl_o) b0++;
    end
    chk("mr_quiet", b0, 0);
    // back in IDLE: a fresh request stalls combinationally and is served normally
    sl_mode = 0; sl_waits = 0; sl_data = 32'hCAFEF00D;
    access(1'b0, 3'b010, 32'hA00, 32'h0);
    chk("mr_after_ack_k", r_ack_k, 2);
    chk("mr_after_rdata", r_rdata, 32'hCAFEF00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
